// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the multiplier scheduler.
// Tag ids are sized for the largest supported requester count (16).
package mult_sched_pkg;

    localparam int OPWIDTH_DEF = 16;
    localparam int LATENCY_DEF = 6;
    localparam int NREQ_MAX    = 16;
    localparam int ID_W        = $clog2(NREQ_MAX);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } mult_sched_tag_t;

    function automatic logic [NREQ_MAX-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NREQ_MAX-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [NREQ_MAX-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) id = ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/mult_sched_arb.sv
// Single-grant arbiter: round-robin when MULT_SCHED_RR_EN is defined,
// otherwise fixed priority with the lowest index winning (no state at all).
module mult_sched_arb
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
`ifdef MULT_SCHED_RR_EN
    input  logic            clk,
    input  logic            rst_n,
`endif
    input  logic [NREQ-1:0] vld,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id
);

`ifdef MULT_SCHED_RR_EN
    // ptr holds the last granted index; the search begins just after it.
    logic [ID_W-1:0] ptr;

    always_comb begin : rr_search
        int  idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (vld[idx] && !found) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= gnt_id;
        end
    end
`else
    always_comb begin : fixed_search
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (vld[i] && !found) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end
`endif

    assign gnt_id = onehot_to_id(NREQ_MAX'(gnt));

endmodule

// File: rtl/mult_sched.sv
// Shares one free-running pipelined multiplier between NREQ requesters and
// routes each product back by a tag pipe. Arbitration mode: MULT_SCHED_RR_EN.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int OPWIDTH = OPWIDTH_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic [NREQ-1:0]              i_req_vld,
    input  logic [NREQ*OPWIDTH-1:0]      i_req_a,
    input  logic [NREQ*OPWIDTH-1:0]      i_req_b,
    input  logic [NREQ-1:0]              i_req_tc,
    output logic [NREQ-1:0]              o_req_rdy,
    output logic [OPWIDTH-1:0]           o_multa,
    output logic [OPWIDTH-1:0]           o_multb,
    output logic                         o_multa_ns,
    output logic                         o_multb_ns,
    input  logic [2*OPWIDTH-1:0]         i_product,
    output logic [NREQ-1:0]              o_rsp_vld,
    output logic [2*OPWIDTH-1:0]         o_rsp_product,
    output logic [$clog2(LATENCY+1)-1:0] o_inflight
);

    localparam int CNTW = $clog2(LATENCY+1);

    logic [NREQ-1:0]    gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               grant;
    logic [OPWIDTH-1:0] sel_a;
    logic [OPWIDTH-1:0] sel_b;
    logic               sel_tc;
    logic               tc_q;
    mult_sched_tag_t    push;
    mult_sched_tag_t    tag_pipe [LATENCY];
    mult_sched_tag_t    tail;
    mult_sched_tag_t    align_q;
    logic [NREQ-1:0]    rsp_next;

    mult_sched_arb #(.NREQ(NREQ)) u_arb (
`ifdef MULT_SCHED_RR_EN
        .clk    (i_clk),
        .rst_n  (i_rstn),
`endif
        .vld    (i_req_vld),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Handshake: transfer when i_req_vld[k] & o_req_rdy[k]; ready is
    // one-hot, combinational, held low during reset; no response backpressure.
    assign o_req_rdy = i_rstn ? gnt : '0;
    assign grant     = |o_req_rdy;

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_tc = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                sel_a  = i_req_a[k*OPWIDTH +: OPWIDTH];
                sel_b  = i_req_b[k*OPWIDTH +: OPWIDTH];
                sel_tc = i_req_tc[k];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_multa <= '0;
            o_multb <= '0;
            tc_q    <= 1'b0;
        end else if (grant) begin
            o_multa <= sel_a;
            o_multb <= sel_b;
            tc_q    <= sel_tc;
        end
    end

    assign o_multa_ns = tc_q;
    assign o_multb_ns = tc_q;

    assign push = {grant, gnt_id};
    assign tail = tag_pipe[LATENCY-1];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= push;
            for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // The tag leaves the tail one edge before its product reaches i_product,
    // so it waits one cycle in align_q before the response is registered.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            align_q <= '0;
        end else begin
            align_q <= tail;
        end
    end

    always_comb begin
        rsp_next = '0;
        for (int k = 0; k < NREQ; k++) begin
            rsp_next[k] = align_q.vld && (align_q.id == ID_W'(k));
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_rsp_vld     <= '0;
            o_rsp_product <= '0;
        end else begin
            o_rsp_vld <= rsp_next;
            if (align_q.vld) o_rsp_product <= i_product;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_inflight <= '0;
        end else begin
            case ({push.vld, tail.vld})
                2'b10:   o_inflight <= o_inflight + CNTW'(1);
                2'b01:   o_inflight <= o_inflight - CNTW'(1);
                default: o_inflight <= o_inflight;
            endcase
        end
    end

endmodule
